// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: client request/response and RAM-engine handshake bundle for mem_req_arbiter
interface mem_req_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req_in;
   logic [ADDR_W-1:0] if_addr_in;
   logic              if_ack_out;
   logic [DATA_W-1:0] if_rdata_out;
   logic              lb_req_in;
   logic [ADDR_W-1:0] lb_addr_in;
   logic [1:0]        lb_size_in;
   logic              lb_signed_in;
   logic              lb_ack_out;
   logic [DATA_W-1:0] lb_rdata_out;
   logic              st_req_in;
   logic [ADDR_W-1:0] st_addr_in;
   logic [1:0]        st_size_in;
   logic [DATA_W-1:0] st_wdata_in;
   logic              st_ack_out;
   logic              mem_req_valid_out;
   logic              mem_req_ready_in;
   logic              mem_rw_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [1:0]        mem_size_out;
   logic [DATA_W-1:0] mem_wdata_out;
   logic              mem_resp_valid_in;
   logic [DATA_W-1:0] mem_resp_data_in;
   modport master (
      input  if_req_in, if_addr_in, lb_req_in, lb_addr_in, lb_size_in, lb_signed_in,
             st_req_in, st_addr_in, st_size_in, st_wdata_in,
             mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
      output if_ack_out, if_rdata_out, lb_ack_out, lb_rdata_out, st_ack_out,
             mem_req_valid_out, mem_rw_out, mem_addr_out, mem_size_out, mem_wdata_out
   );
   modport slave (
      output if_req_in, if_addr_in, lb_req_in, lb_addr_in, lb_size_in, lb_signed_in,
             st_req_in, st_addr_in, st_size_in, st_wdata_in,
             mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
      input  if_ack_out, if_rdata_out, lb_ack_out, lb_rdata_out, st_ack_out,
             mem_req_valid_out, mem_rw_out, mem_addr_out, mem_size_out, mem_wdata_out
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter of fetch/load/store clients onto the byte-serial RAM engine
module mem_req_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic clk_in,
   input logic rst_in,
   input logic rdy_in,
   input logic flush_in,
   mem_req_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DROP} state_t;
   localparam logic [1:0] IF = 2'd0;
   localparam logic [1:0] LB = 2'd1;
   localparam logic [1:0] ST = 2'd2;
   state_t state;
   logic [1:0] rr_ptr, owner, sel, p1, p2;
   logic [3:0] req;
   logic lb_signed, read_flush;
   logic [DATA_W-1:0] d, lb_data;
   function automatic logic [1:0] nxt(input logic [1:0] p);
      return p == ST ? IF : p + 2'd1;
   endfunction
   // a flush suppresses speculative reads in the grant cycle; committed stores still compete
   assign req = {1'b0, bus.st_req_in, bus.lb_req_in & ~flush_in, bus.if_req_in & ~flush_in};
   assign read_flush = flush_in & (owner != ST);
   assign d = bus.mem_resp_data_in;
   always_comb begin
      p1 = nxt(rr_ptr);
      p2 = nxt(p1);
      sel = req[rr_ptr] ? rr_ptr : req[p1] ? p1 : p2;
   end
   assign lb_data = bus.mem_size_out == 2'd0 ? {{(DATA_W-8){lb_signed & d[7]}}, d[7:0]} :
                    bus.mem_size_out == 2'd1 ? {{(DATA_W-16){lb_signed & d[15]}}, d[15:0]} : d;
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         rr_ptr <= IF;
         owner <= IF;
         lb_signed <= 1'b0;
         bus.if_ack_out <= 1'b0;
         bus.lb_ack_out <= 1'b0;
         bus.st_ack_out <= 1'b0;
         bus.if_rdata_out <= '0;
         bus.lb_rdata_out <= '0;
         bus.mem_req_valid_out <= 1'b0;
         bus.mem_rw_out <= 1'b0;
         bus.mem_addr_out <= '0;
         bus.mem_size_out <= '0;
         bus.mem_wdata_out <= '0;
      end else if (rdy_in) begin
         bus.if_ack_out <= 1'b0;
         bus.lb_ack_out <= 1'b0;
         bus.st_ack_out <= 1'b0;
         if (flush_in) rr_ptr <= ST;
         case (state)
            IDLE: if (|req) begin
               owner <= sel;
               rr_ptr <= nxt(sel);
               lb_signed <= bus.lb_signed_in;
               bus.mem_rw_out <= sel == ST;
               bus.mem_addr_out <= sel == IF ? bus.if_addr_in : sel == LB ? bus.lb_addr_in : bus.st_addr_in;
               bus.mem_size_out <= sel == IF ? 2'd2 : sel == LB ? bus.lb_size_in : bus.st_size_in;
               bus.mem_wdata_out <= sel == ST ? bus.st_wdata_in : '0;
               bus.mem_req_valid_out <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: if (read_flush || bus.mem_req_ready_in) begin
               bus.mem_req_valid_out <= 1'b0;
               // a read already accepted by the engine must still have its response swallowed
               state <= !read_flush ? WAIT : bus.mem_req_ready_in ? DROP : IDLE;
            end
            WAIT: if (bus.mem_resp_valid_in) begin
               state <= IDLE;
               if (!read_flush) begin
                  bus.if_ack_out <= owner == IF;
                  bus.lb_ack_out <= owner == LB;
                  bus.st_ack_out <= owner == ST;
                  if (owner == IF) bus.if_rdata_out <= d;
                  if (owner == LB) bus.lb_rdata_out <= lb_data;
               end
            end else if (read_flush) begin
               state <= DROP;
            end
            DROP: if (bus.mem_resp_valid_in) state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the three memory clients (instruction fetch, load buffer, ROB store commit) and the byte-serial RAM engine.
- Latches one request at a time and grants the engine round-robin.
- Tracks the outstanding transaction and routes the response back to its owner.
- Handles pipeline flush: cancels speculative reads and always completes committed stores.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, client data width.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  ROB flush, one-cycle pulse
- if_req_in  in  1  fetch request, level, held until ack
- if_addr_in  in  ADDR_W  fetch PC
- if_ack_out  out  1  one-cycle pulse, if_rdata_out valid
- if_rdata_out  out  DATA_W  instruction word
- lb_req_in  in  1  load request, level
- lb_addr_in  in  ADDR_W  load address
- lb_size_in  in  2  0=byte, 1=half, 2=word
- lb_signed_in  in  1  1 = sign-extend result
- lb_ack_out  out  1  one-cycle pulse
- lb_rdata_out  out  DATA_W  extended load data
- st_req_in  in  1  store request, level
- st_addr_in  in  ADDR_W  store address
- st_size_in  in  2  store size, same encoding as lb_size_in
- st_wdata_in  in  DATA_W  store data, low bytes used
- st_ack_out  out  1  one-cycle pulse, store done
- mem_req_valid_out  out  1  request to engine
- mem_req_ready_in  in  1  engine accepts request
- mem_rw_out  out  1  0=read, 1=write
- mem_addr_out  out  ADDR_W  latched address
- mem_size_out  out  2  latched size
- mem_wdata_out  out  DATA_W  latched write data
- mem_resp_valid_in  in  1  engine done, one-cycle pulse
- mem_resp_data_in  in  DATA_W  raw little-endian bytes, zero above size

Behaviour:
- Interface (already decided): one clock, clk_in; rst_in is asynchronous, active-high.
- Reset clears all state and outputs to 0: state=IDLE, rr_ptr=IF, owner=IF, all acks 0, rdata 0, mem_* outputs 0.
- rdy_in=0: no register changes. Outputs hold. Response pulses arriving during the freeze are the engine's responsibility; the engine is frozen by the same rdy_in.
- States and transitions:
  - IDLE: grant the first requester found by scanning from rr_ptr in order IF→LB→ST→IF. On grant, latch addr/size/wdata/rw/owner, set rr_ptr to owner+1 (mod 3), go to ISSUE. No requester: stay in IDLE.
  - ISSUE: mem_req_valid_out=1. On mem_req_ready_in=1, go to WAIT; valid drops the next cycle.
  - WAIT: on mem_resp_valid_in=1, drive the owner's ack for exactly one cycle with rdata registered in the same edge, then go to IDLE.
  - DROP: on mem_resp_valid_in=1, go to IDLE with no ack.
- Grant latency: request seen in IDLE → mem_req_valid_out high on the next cycle. Back-to-back: an ack cycle is also IDLE-entry, so the next grant occurs one cycle after the ack.
- IF requests are always size=word, rw=read. ST requests are rw=write.
- LB data: size 0 gives bits [7:0], extended to 32 bits; size 1 gives bits [15:0], extended. Extension is sign if lb_signed_in was 1 at grant (value latched), else zero. Size 2 passes through. Size 3 is treated as word.
- ST data: mem_wdata_out = st_wdata_in latched; the engine uses the low size bytes.
- Flush:
  - In IDLE: IF and LB requests are ignored that cycle; ST may still be granted.
  - In ISSUE/WAIT with a read owner: ISSUE with ready=0 → IDLE, valid dropped, no ack. ISSUE with ready=1, or WAIT → DROP.
  - In ISSUE/WAIT with a store owner: unaffected; the ack is still delivered.
  - In DROP: no effect.
  - Flush also resets rr_ptr to ST, so a committed store following a flush wins arbitration.
- Flush coinciding with mem_resp_valid_in in WAIT (read): the response is discarded, no ack, go to IDLE.
- Requests dropped by a client before ack are protocol errors; behaviour is undefined.
- Exactly one transaction is outstanding; no queueing beyond the latch.

Test Plan:
- Reset mid-WAIT (rst_in asserted asynchronously between edges): all outputs 0 immediately; after release, IF at 0x0000_1000 is granted first.
- All three requesters asserted continuously; engine answers 2 cycles after ready: grant order IF, LB, ST, IF, LB, ...; each ack is one cycle; no grant while busy.
- LB byte at 0x20, response 0x0000_0080: signed=1 → lb_rdata_out=0xFFFF_FF80; signed=0 → 0x0000_0080. Half response 0x0000_8001, signed=1 → 0xFFFF_8001.
- Flush during IF WAIT: resp 0xDEADBEEF arrives later; if_ack_out never pulses, state returns to IDLE. A pending ST is granted next even though rr_ptr was at LB.
- Flush during ST WAIT (SW 0x1234_5678 to 0x100): st_ack_out pulses on resp; mem_wdata_out=0x1234_5678, mem_size_out=2, mem_rw_out=1 held throughout ISSUE.
- rdy_in low for 3 cycles in ISSUE: mem_req_valid_out and mem_addr_out stay constant; after release, the handshake completes normally.
